// File: rtl/memory_ctrl_be_pkg.sv
// Shared types and constants for the byte-enable memory controller.
// Latency counter width is sized for the largest supported response latency.
package memory_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int unsigned RESP_LAT_MIN = 1;
   localparam int unsigned RESP_LAT_MAX = 8;

   function automatic int unsigned cnt_width();
      return $clog2(RESP_LAT_MAX);
   endfunction

   localparam int unsigned CNT_W = cnt_width();

endpackage

// File: rtl/memory_ctrl_be_mem_array.sv
// Byte-enabled storage array with a registered read snapshot.
// The snapshot register doubles as the response data register.
module mem_array_be #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned ADDR_SIZE = $clog2(DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [WIDTH/8-1:0]   i_be,
   input  logic [ADDR_SIZE-1:0] i_addr,
   input  logic [WIDTH-1:0]     i_wdata,
   input  logic                 i_clr,
   input  logic                 i_ld,
   input  logic                 i_rd,
   input  logic                 i_qclr,
   output logic [WIDTH-1:0]     o_q
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         for (int unsigned b = 0; b < WIDTH/8; b++) begin
            if (i_be[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   // Writes and errored reads load zero so the response reads back as 0.
   always_ff @(posedge i_clk) begin
      if (i_qclr) begin
         r_q <= '0;
      end else if (i_ld) begin
         r_q <= i_rd ? r_mem[i_addr] : '0;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/memory_ctrl_be.sv
// Request/response front end for a single-port byte-enabled RAM.
// One outstanding transaction, configurable response latency, range error.
module memory_ctrl_be
   import memory_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_SIZE  = $clog2(DEPTH),
   parameter int unsigned RESP_LAT   = 1,
   parameter int unsigned CLR_ON_RST = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic                 wr_rd_i,
   input  logic [ADDR_SIZE-1:0] addr_i,
   input  logic [WIDTH-1:0]     wdata_i,
   input  logic [WIDTH/8-1:0]   wstrb_i,
   output logic                 rvalid_o,
   input  logic                 rready_i,
   output logic [WIDTH-1:0]     rdata_o,
   output logic                 err_o
);

   if (RESP_LAT < RESP_LAT_MIN || RESP_LAT > RESP_LAT_MAX) begin : g_bad_lat
      $error("memory_ctrl_be: RESP_LAT must be in 1..8");
   end
   if (WIDTH % 8 != 0) begin : g_bad_width
      $error("memory_ctrl_be: WIDTH must be a multiple of 8");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("memory_ctrl_be: DEPTH must be at least 2");
   end

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((RESP_LAT > 1) ? RESP_LAT - 2 : 0);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             w_accept;
   logic             w_in_range;
   logic             w_done;
   logic             w_clr;
   logic [WIDTH-1:0] w_q;

   // Gating with rst_i keeps ready low for the whole reset window.
   assign ready_o    = rst_i && (r_state == IDLE);
   assign rvalid_o   = (r_state == RESP);
   assign w_accept   = valid_i && ready_o;
   assign w_done     = rvalid_o && rready_i;
   assign w_in_range = {1'b0, addr_i} < (ADDR_SIZE+1)'(DEPTH);
   assign w_clr      = (CLR_ON_RST != 0) && !rst_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_err <= !w_in_range;
                  if (RESP_LAT == 1) begin
                     r_state <= RESP;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= LAT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rready_i) begin
                  r_state <= IDLE;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mem_array_be #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_mem (
      .i_clk   (clk_i),
      .i_we    (w_accept && wr_rd_i && w_in_range),
      .i_be    (wstrb_i),
      .i_addr  (addr_i),
      .i_wdata (wdata_i),
      .i_clr   (w_clr),
      .i_ld    (w_accept),
      .i_rd    (!wr_rd_i && w_in_range),
      .i_qclr  (!rst_i || w_done),
      .o_q     (w_q)
   );

   assign rdata_o = w_q;
   assign err_o   = r_err;

endmodule

// File: tb/tb_memory_ctrl_be.sv
// Directed bench for memory_ctrl_be: three instances cover latency 1/4/3,
// a non-power-of-two depth, back-pressure and reset during a transaction.
module tb_memory_ctrl_be;

   logic        clk;
   logic        rst    [3];
   logic        valid  [3];
   logic        ready  [3];
   logic        wr     [3];
   logic [5:0]  addr   [3];
   logic [31:0] wdata  [3];
   logic [3:0]  wstrb  [3];
   logic        rvalid [3];
   logic        rready [3];
   logic [31:0] rdata  [3];
   logic        err    [3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          k;
      logic        w;
      logic [5:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] er;
      logic        ee;
   } vec_t;

   vec_t tbl [14];

   memory_ctrl_be #(.WIDTH(32), .DEPTH(48), .RESP_LAT(1), .CLR_ON_RST(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst[0]), .valid_i(valid[0]), .ready_o(ready[0]),
      .wr_rd_i(wr[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .wstrb_i(wstrb[0]),
      .rvalid_o(rvalid[0]), .rready_i(rready[0]), .rdata_o(rdata[0]), .err_o(err[0]));

   memory_ctrl_be #(.WIDTH(32), .DEPTH(64), .RESP_LAT(4), .CLR_ON_RST(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst[1]), .valid_i(valid[1]), .ready_o(ready[1]),
      .wr_rd_i(wr[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .wstrb_i(wstrb[1]),
      .rvalid_o(rvalid[1]), .rready_i(rready[1]), .rdata_o(rdata[1]), .err_o(err[1]));

   memory_ctrl_be #(.WIDTH(32), .DEPTH(64), .RESP_LAT(3), .CLR_ON_RST(1)) u_dut2 (
      .clk_i(clk), .rst_i(rst[2]), .valid_i(valid[2]), .ready_o(ready[2]),
      .wr_rd_i(wr[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .wstrb_i(wstrb[2]),
      .rvalid_o(rvalid[2]), .rready_i(rready[2]), .rdata_o(rdata[2]), .err_o(err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : 3;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the response handshake edge.
   task automatic do_txn(input int k, input logic w, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic ee,
                         input string nm);
      int n;
      wr[k] = w; addr[k] = a; wdata[k] = d; wstrb[k] = s; valid[k] = 1'b1;
      n = 0;
      while (ready[k] !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({nm, " ready"}, 32'(ready[k]), 32'd1);
      @(posedge clk); #1;
      valid[k] = 1'b0;
      n = 1;
      while (rvalid[k] !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk({nm, " latency"}, 32'(n), 32'(lat_of(k)));
      chk({nm, " rdata"}, rdata[k], er);
      chk({nm, " err"}, 32'(err[k]), 32'(ee));
      @(posedge clk); #1;
   endtask

   initial begin
      logic seen;

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b0; valid[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0;
         wdata[k] = '0; wstrb[k] = '0; rready[k] = 1'b1;
      end

      tbl[0]  = '{0, 1'b0, 6'd5,  32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0};
      tbl[1]  = '{0, 1'b1, 6'd3,  32'hAABB_CCDD, 4'hF, 32'h0000_0000, 1'b0};
      tbl[2]  = '{0, 1'b1, 6'd3,  32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
      tbl[3]  = '{0, 1'b0, 6'd3,  32'h0000_0000, 4'h0, 32'hAA22_CC44, 1'b0};
      tbl[4]  = '{0, 1'b1, 6'd47, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
      tbl[5]  = '{0, 1'b1, 6'd50, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
      tbl[6]  = '{0, 1'b0, 6'd50, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
      tbl[7]  = '{0, 1'b0, 6'd47, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};
      tbl[8]  = '{0, 1'b1, 6'd3,  32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
      tbl[9]  = '{0, 1'b0, 6'd3,  32'h0000_0000, 4'h0, 32'hAA22_CC44, 1'b0};
      tbl[10] = '{0, 1'b1, 6'd3,  32'h5566_7788, 4'hA, 32'h0000_0000, 1'b0};
      tbl[11] = '{0, 1'b0, 6'd3,  32'h0000_0000, 4'h0, 32'h5522_7744, 1'b0};
      tbl[12] = '{0, 1'b0, 6'd63, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
      tbl[13] = '{1, 1'b1, 6'd9,  32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};

      // Reset held for two edges on every instance.
      repeat (2) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) chk($sformatf("d%0d ready in reset", k), 32'(ready[k]), 32'd0);
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d%0d rvalid reset", k), 32'(rvalid[k]), 32'd0);
         chk($sformatf("d%0d rdata reset", k), rdata[k], 32'd0);
         chk($sformatf("d%0d err reset", k), 32'(err[k]), 32'd0);
         rst[k] = 1'b1;
      end
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("d%0d ready after release", k), 32'(ready[k]), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         do_txn(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].er, tbl[i].ee,
                $sformatf("v%0d", i));
      end

      // Latency 4 with six cycles of response back-pressure.
      rready[1] = 1'b0;
      wr[1] = 1'b0; addr[1] = 6'd9; valid[1] = 1'b1;
      @(posedge clk); #1;
      valid[1] = 1'b0;
      for (int s = 1; s <= 4; s++) begin
         chk($sformatf("lat4 ready s%0d", s), 32'(ready[1]), 32'd0);
         chk($sformatf("lat4 rvalid s%0d", s), 32'(rvalid[1]), (s == 4) ? 32'd1 : 32'd0);
         if (s < 4) begin
            @(posedge clk); #1;
         end
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk($sformatf("stall rvalid %0d", i), 32'(rvalid[1]), 32'd1);
         chk($sformatf("stall ready %0d", i), 32'(ready[1]), 32'd0);
         chk($sformatf("stall rdata %0d", i), rdata[1], 32'hCAFE_F00D);
         chk($sformatf("stall err %0d", i), 32'(err[1]), 32'd0);
      end
      rready[1] = 1'b1;
      @(posedge clk); #1;
      chk("stall release ready", 32'(ready[1]), 32'd1);
      chk("stall release rvalid", 32'(rvalid[1]), 32'd0);
      chk("stall release rdata", rdata[1], 32'd0);

      // Errored read held under back-pressure.
      rready[0] = 1'b0;
      wr[0] = 1'b0; addr[0] = 6'd50; valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("errstall rvalid %0d", i), 32'(rvalid[0]), 32'd1);
         chk($sformatf("errstall err %0d", i), 32'(err[0]), 32'd1);
         chk($sformatf("errstall rdata %0d", i), rdata[0], 32'd0);
         @(posedge clk); #1;
      end
      rready[0] = 1'b1;
      @(posedge clk); #1;
      chk("errstall release err", 32'(err[0]), 32'd0);
      chk("errstall release ready", 32'(ready[0]), 32'd1);

      // Reset one cycle into a latency-3 read: no response, memory cleared.
      do_txn(2, 1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, "d2 wr5");
      do_txn(2, 1'b0, 6'd5, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, "d2 rd5");
      wr[2] = 1'b0; addr[2] = 6'd5; valid[2] = 1'b1;
      @(posedge clk); #1;
      valid[2] = 1'b0;
      rst[2] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (i == 1) rst[2] = 1'b1;
         if (rvalid[2] === 1'b1) seen = 1'b1;
      end
      chk("d2 no response after reset", 32'(seen), 32'd0);
      do_txn(2, 1'b0, 6'd5, 32'd0, 4'h0, 32'd0, 1'b0, "d2 rd5 cleared");
      do_txn(2, 1'b1, 6'd7, 32'h0BAD_F00D, 4'h3, 32'd0, 1'b0, "d2 wr7");
      do_txn(2, 1'b0, 6'd7, 32'd0, 4'h0, 32'h0000_F00D, 1'b0, "d2 rd7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_ctrl_be.md
Name: memory_ctrl_be

Overview:
- Second-generation front-door memory. Single-port synchronous RAM behind a request/response handshake.
- Adds per-byte write strobes, a configurable response latency, and a response channel with back-pressure.
- Adds an out-of-range error for addresses at or above DEPTH when DEPTH is not a power of two.
- Sits on the register/data bus as a slave; one outstanding transaction at a time.

Parameters:
- WIDTH, 32: data width in bits; must be a multiple of 8.
- DEPTH, 64: number of words; any value ≥ 2.
- ADDR_SIZE, $clog2(DEPTH): address width.
- RESP_LAT, 1: cycles from request acceptance to rvalid_o; legal range 1..8.
- CLR_ON_RST, 1: 1 = every word is cleared while reset is asserted; 0 = contents are preserved across reset.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request ready.
- wr_rd_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_SIZE  word address.
- wdata_i  in  WIDTH  write data.
- wstrb_i  in  WIDTH/8  byte enables for writes; ignored on reads.
- rvalid_o  out  1  response valid.
- rready_i  in  1  response ready.
- rdata_o  out  WIDTH  read data; 0 for writes and for errored reads.
- err_o  out  1  1 = address out of range.

Behaviour:
- Reset: sampled on the rising edge when rst_i==0.
  - Next state is IDLE; rvalid_o=0, rdata_o=0, err_o=0; latency counter = 0.
  - ready_o is 0 while rst_i==0 and 1 in the first cycle after reset is released.
  - If CLR_ON_RST==1, all words read 0 afterwards.
  - Reset mid-transaction discards the pending response. No rvalid_o is emitted for it.
- States:
  - IDLE: ready_o=1.
  - WAIT: counting latency; ready_o=0, rvalid_o=0.
  - RESP: rvalid_o=1, ready_o=0.
- ready_o and rvalid_o are decoded directly from the registered state.
- Acceptance: valid_i && ready_o at edge T.
  - Address, data, strobes and the wr_rd_i value are captured at T.
  - valid_i while ready_o==0 is ignored. The requester must hold its signals until accepted.
- Write at T:
  - For each byte b with wstrb_i[b]==1, mem[addr][8b+7:8b] is updated at edge T. Unstrobed bytes are unchanged.
  - wstrb_i==0 is a legal no-op write that still returns a response with err_o=0.
- Read at T: mem[addr] is snapshotted at T into the response register.
- Out of range (addr_i ≥ DEPTH): no memory update; rdata_o=0; err_o=1.
- Transitions:
  - IDLE → RESP when RESP_LAT==1.
  - IDLE → WAIT otherwise, with the counter loaded to RESP_LAT-2.
  - WAIT decrements the counter each cycle and goes to RESP when it reaches 0.
  - rvalid_o therefore first rises in cycle T+RESP_LAT.
- RESP: rdata_o and err_o are held stable while rvalid_o && !rready_i, for any stall length.
  - On rvalid_o && rready_i: go to IDLE. ready_o=1 the next cycle; rdata_o and err_o clear to 0.
- Minimum spacing between accepts is RESP_LAT+1 cycles (rready_i tied to 1).
- rready_i asserted with no response pending is ignored.

Decomposition:
- Package memory_ctrl_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Latency counter width function: $clog2(8) = 3 bits.
  - Constants RESP_LAT_MIN=1 and RESP_LAT_MAX=8 for elaboration-time parameter checks.
- Sub-module mem_array_be holds the storage array and read snapshot.
  - Inputs: clk, we, per-byte enables, address, wdata, clear.
  - Output: registered read word.
- The top level owns the FSM, range check and response registers.

Test Plan:
- Reset/clear: hold rst_i=0 for 2 cycles with CLR_ON_RST=1, then read addr 5 → rdata_o=0x00000000, err_o=0; ready_o=1 in the first cycle after release.
- Strobed write: write 0xAABBCCDD to addr 3 with wstrb=4'hF, then 0x11223344 with wstrb=4'b0101, then read → rdata_o=0xAA22CC44.
- Latency: RESP_LAT=4, read accepted at cycle 10 → rvalid_o rises in cycle 14; ready_o=0 in cycles 11-14.
- Back-pressure: hold rready_i=0 for 6 cycles after rvalid_o rises → rdata_o and err_o stable, ready_o=0 throughout; rready_i=1 → ready_o=1 next cycle.
- Range error: DEPTH=48, write 0xFFFF_FFFF to addr 50 → err_o=1; read addr 50 → rdata_o=0, err_o=1; read addr 47 → its prior value unchanged.
- Reset mid-op: RESP_LAT=3, accept a read, assert rst_i=0 one cycle later → no rvalid_o ever; after release, a new read completes normally.
